// File: rtl/if_id_skid_stage.sv
// IF->ID stage register with 2-entry skid buffer and synchronous flush.
// Optional perf counters (stall_cnt, flush_cnt) under IF_ID_SKID_PERF_EN.
module if_id_skid_stage #(
  parameter int INSTR_W = 32,
  parameter int LANES   = 1,
  parameter int PC_W    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*INSTR_W-1:0] in_instr,
  input  logic [LANES-1:0]         in_lane_v,
  input  logic [PC_W-1:0]          in_pcp4,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*INSTR_W-1:0] out_instr,
  output logic [LANES-1:0]         out_lane_v,
  output logic [PC_W-1:0]          out_pcp4,
  input  logic                     flush
`ifdef IF_ID_SKID_PERF_EN
  ,
  output logic [31:0]              stall_cnt,
  output logic [31:0]              flush_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state, state_n;

  logic [LANES*INSTR_W-1:0] skid_instr;
  logic [LANES-1:0]         skid_lane_v;
  logic [PC_W-1:0]          skid_pcp4;

  logic ld_main_in;
  logic ld_main_skid;
  logic ld_skid;

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);

  always_comb begin
    state_n      = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_valid) begin
          state_n    = ONE;
          ld_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_valid && out_ready) begin
          ld_main_in = 1'b1;
        end else if (in_valid) begin
          state_n = TWO;
          ld_skid = 1'b1;
        end else if (out_ready) begin
          state_n = EMPTY;
        end
      end
      TWO: begin
        if (out_ready) begin
          state_n      = ONE;
          ld_main_skid = 1'b1;
        end
      end
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      state <= EMPTY;
    end else begin
      state <= state_n;
    end
  end

  // Reset and flush both zero the held bundles so decode sees NOPs.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      out_instr   <= '0;
      out_lane_v  <= '0;
      out_pcp4    <= '0;
      skid_instr  <= '0;
      skid_lane_v <= '0;
      skid_pcp4   <= '0;
    end else begin
      if (ld_main_in) begin
        out_instr  <= in_instr;
        out_lane_v <= in_lane_v;
        out_pcp4   <= in_pcp4;
      end else if (ld_main_skid) begin
        out_instr  <= skid_instr;
        out_lane_v <= skid_lane_v;
        out_pcp4   <= skid_pcp4;
      end
      if (ld_skid) begin
        skid_instr  <= in_instr;
        skid_lane_v <= in_lane_v;
        skid_pcp4   <= in_pcp4;
      end
    end
  end

`ifdef IF_ID_SKID_PERF_EN
  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != 32'hFFFF_FFFF) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
      if (flush && out_valid && flush_cnt != 32'hFFFF_FFFF) begin
        flush_cnt <= flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
- Parametrised IF→ID pipeline stage register with a valid/ready handshake, a 2-entry skid buffer, and a synchronous flush.
- Carries LANES fetched instructions plus one PC+4 per bundle, so the front end can widen fetch without retiming the decode boundary.
- Sits between fetch/instruction memory and decode.
- A flush inserts zero bundles (NOP = 32'h0).

Parameters:
- INSTR_W, 32, width of one instruction slot.
- LANES, 1, instructions per fetch bundle (≥1).
- PC_W, 32, width of the PC+4 field.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  fetch offers a bundle.
- in_ready  out  1  stage can accept; registered, depends only on state.
- in_instr  in  LANES*INSTR_W  instruction bundle; lane 0 in the LSBs.
- in_lane_v  in  LANES  per-lane valid mask.
- in_pcp4  in  PC_W  PC+4 of lane 0.
- out_valid  out  1  bundle available to decode.
- out_ready  in  1  decode accepts; low means decode stall.
- out_instr  out  LANES*INSTR_W  registered bundle.
- out_lane_v  out  LANES  registered lane mask.
- out_pcp4  out  PC_W  registered PC+4.
- flush  in  1  discard all held bundles (branch/jump redirect).

Behaviour:
- Transfer rules: an input transfer occurs on an edge where in_valid & in_ready. An output transfer occurs on an edge where out_valid & out_ready.
- Storage: main register (MAIN) drives the out_* ports directly. A skid register (SKID) holds the overflow bundle.
- States: EMPTY (0 held), ONE (MAIN valid), TWO (MAIN+SKID valid).
- in_ready = (state != TWO). out_valid = (state != EMPTY).
- EMPTY:
  - in_valid → ONE, MAIN ← in.
  - Otherwise stay in EMPTY.
- ONE:
  - in_valid & out_ready → ONE, MAIN ← in.
  - in_valid & !out_ready → TWO, SKID ← in.
  - !in_valid & out_ready → EMPTY.
  - Otherwise hold.
- TWO:
  - out_ready → ONE, MAIN ← SKID.
  - Otherwise hold. Input is ignored because in_ready = 0.
- Latency: 1 cycle from an accept in EMPTY to out_valid. Full throughput is 1 bundle/cycle when out_ready stays high.
- Stability: while out_valid & !out_ready, all out_* ports hold constant.
- flush = 1 at an edge:
  - state ← EMPTY; MAIN, SKID, and lane masks ← 0.
  - Any same-edge input is discarded, and the upstream handshake is not honoured.
  - flush takes priority over in_valid and out_ready.
- Reset: rst_n = 0 at an edge has the same effect as flush.
  - After reset: out_valid = 0, in_ready = 1, out_instr = 0, out_lane_v = 0, out_pcp4 = 0.
  - Reset mid-operation drops held bundles without emitting them.
- Lane mask: carried unchanged with its bundle. A bundle with in_lane_v = 0 but in_valid = 1 is still accepted and passed through; decode treats it as a bubble.
- No combinational path from in_* or out_ready to in_ready or out_*.

Optional Feature:
- Macro: IF_ID_SKID_PERF_EN.
- When defined, two extra outputs are added:
  - stall_cnt[31:0]: increments every cycle where out_valid & !out_ready.
  - flush_cnt[31:0]: increments on each flush that discards ≥1 valid bundle.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset (not on flush).
- When undefined: no counters and no extra ports; behaviour is otherwise identical.

Test Plan:
- Reset then stream: rst_n low 2 cycles, then release with in_valid = 1 every cycle, instr = 32'h20080005 + k, pcp4 = 4 + 4k, out_ready = 1. Required: out_valid from cycle 1, in_ready = 1 throughout, one bundle out per cycle in order, no drops.
- Decode stall: in state ONE holding A, drive out_ready = 0 with B offered. Required: state TWO, in_ready = 0, out_instr = A stable. Raise out_ready: A then B emerge on consecutive cycles, and in_ready rises one cycle after A is taken.
- Flush while full: in TWO, pulse flush with in_valid = 1 (C). Required next cycle: out_valid = 0, out_instr = 0, out_pcp4 = 0, C not captured; flush_cnt = 1 if IF_ID_SKID_PERF_EN.
- LANES = 2 build: in_instr = {32'hAC010004, 32'h8C010000}, in_lane_v = 2'b01. Required: out_instr and out_lane_v = 2'b01 reproduced exactly.
- Mid-stall reset: in TWO with out_ready = 0, assert rst_n = 0 for 1 cycle. Required: out_valid = 0 and in_ready = 1 after the edge. With the macro defined, stall_cnt = 0 after reset, and stall_cnt = 5 after 5 subsequent stalled cycles.
